maze_map_writer: RTL and testbench

Writable maze store that owns the 20 × 10 tile bitmap and feeds the same row-read interface the pixel-to-wall lookup consumes (row address in, `MAP_WIDTH`-bit row out, bit `MAP_WIDTH-1` = column 0). After reset it initializes the map to a bordered empty maze by sequencing one row per cycle. It then accepts cell- and row-edit commands over a valid/ready handshake from game or editor logic. The outer border is write-protected, so the maze stays closed regardless of command traffic.

---
 rtl/maze_map_writer.sv | 137 +++++++++++++
 tb/tb_maze_map_writer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_map_writer.sv
// maze_map_writer: writable 20x10 maze tile store with a one-row-per-cycle
// init/clear sequencer, border-protected edit commands and a combinational
// row-read port for the pixel-to-wall lookup.
`timescale 1ns/1ps

`ifndef MAP_WIDTH
`define MAP_WIDTH 20
`endif
`ifndef MAP_HEIGHT
`define MAP_HEIGHT 10
`endif

module maze_map_writer (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [3:0]            cmd_row,
  input  logic [4:0]            cmd_col,
  input  logic [`MAP_WIDTH-1:0] cmd_data,
  input  logic [3:0]            rd_addr,
  output logic [`MAP_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  err
);

  localparam int W = `MAP_WIDTH;
  localparam int H = `MAP_HEIGHT;

  localparam logic [3:0]   NUM_ROWS  = 4'(H);
  localparam logic [3:0]   LAST_ROW  = 4'(H - 1);
  localparam logic [4:0]   LAST_COL  = 5'(W - 1);
  localparam logic [W-1:0] ONE_BIT   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] EDGE_BITS = {1'b1, {(W-2){1'b0}}, 1'b1};

  localparam logic [1:0] OP_SET   = 2'b00;
  localparam logic [1:0] OP_CLR   = 2'b01;
  localparam logic [1:0] OP_ROW   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {FILL, IDLE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   fill_cnt_q, fill_cnt_d;
  logic [W-1:0] map_q [H];
  logic [W-1:0] map_d [H];
  logic         busy_q, busy_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         err_q, err_d;

  logic         row_ok;
  logic         cell_ok;
  logic [4:0]   bit_idx;
  logic [W-1:0] cell_mask;

  // Bordered empty maze: solid top/bottom rows, side walls everywhere else.
  function automatic logic [W-1:0] init_row(input logic [3:0] r);
    if (r == 4'd0 || r == LAST_ROW) return '1;
    return EDGE_BITS;
  endfunction

  // Interior-only targets; the strict "< LAST" bounds also reject out-of-range indices.
  assign row_ok    = (cmd_row != 4'd0) && (cmd_row < LAST_ROW);
  assign cell_ok   = row_ok && (cmd_col != 5'd0) && (cmd_col < LAST_COL);
  assign bit_idx   = LAST_COL - cmd_col;
  assign cell_mask = ONE_BIT << bit_idx;

  // Read port reflects the registered map, so same-cycle edits show after the edge.
  assign rd_data   = (rd_addr < NUM_ROWS) ? map_q[rd_addr] : '0;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;
  assign err       = err_q;

  // Next-state logic: fill sequencing in FILL, command decode in IDLE.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    map_d      = map_q;
    err_d      = 1'b0;
    case (state_q)
      FILL: begin
        map_d[fill_cnt_q] = init_row(fill_cnt_q);
        if (fill_cnt_q == LAST_ROW) begin
          state_d    = IDLE;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + 4'd1;
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_SET: begin
              if (cell_ok) map_d[cmd_row] = map_q[cmd_row] | cell_mask;
              else         err_d = 1'b1;
            end
            OP_CLR: begin
              if (cell_ok) map_d[cmd_row] = map_q[cmd_row] & ~cell_mask;
              else         err_d = 1'b1;
            end
            OP_ROW: begin
              if (row_ok) map_d[cmd_row] = cmd_data | EDGE_BITS;
              else        err_d = 1'b1;
            end
            OP_CLEAR: begin
              state_d    = FILL;
              fill_cnt_d = '0;
            end
          endcase
        end
      end
    endcase
    busy_d      = (state_d == FILL);
    cmd_ready_d = (state_d == IDLE);
  end

  // State registers with synchronous reset that wipes the map and restarts the fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      busy_q      <= 1'b1;
      cmd_ready_q <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < H; i++) map_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      err_q       <= err_d;
      for (int i = 0; i < H; i++) map_q[i] <= map_d[i];
    end
  end

endmodule

// File: tb/tb_maze_map_writer.sv
// tb_maze_map_writer: directed self-checking bench for maze_map_writer.
`timescale 1ns/1ps

module tb_maze_map_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_row;
  logic [4:0]  cmd_col;
  logic [19:0] cmd_data;
  logic [3:0]  rd_addr;
  logic [19:0] rd_data;
  logic        busy;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;

  maze_map_writer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_data  (cmd_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Expected init pattern for a row index (0 beyond the map).
  function automatic logic [19:0] exp_init(input int r);
    if (r == 0 || r == 9) return 20'hFFFFF;
    if (r < 10) return 20'h80001;
    return 20'h00000;
  endfunction

  // Combinational read of one row, a little after the current inputs settle.
  task automatic read_row(input logic [3:0] a, output logic [19:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  // Present a command on the bus for the next rising edge.
  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] row,
                           input logic [4:0] col, input logic [19:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = row;
    cmd_col   = col;
    cmd_data  = data;
  endtask

  task automatic test_reset();
    logic [19:0] v;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00; cmd_row = 4'd0; cmd_col = 5'd0; cmd_data = 20'h0;
    rd_addr = 4'd0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: busy=%b ready=%b err=%b, expected 1 0 0", busy, cmd_ready, err);
    end
    read_row(4'd0, v);
    tests_run++;
    if (v !== 20'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_row0: got %h, expected 00000", v);
    end
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i < 10) begin
        tests_run++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL fill_busy cycle %0d: busy=%b ready=%b, expected 1 0", i, busy, cmd_ready);
        end
        if (i == 3) begin
          read_row(4'd2, v);
          tests_run++;
          if (v !== 20'h80001) begin
            tests_failed++;
            $display("[TB] FAIL fill_written_row2: got %h, expected 80001", v);
          end
          read_row(4'd3, v);
          tests_run++;
          if (v !== 20'h00000) begin
            tests_failed++;
            $display("[TB] FAIL fill_unwritten_row3: got %h, expected 00000", v);
          end
        end
      end else begin
        tests_run++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL fill_done: busy=%b ready=%b, expected 0 1", busy, cmd_ready);
        end
      end
    end
    for (int r = 0; r <= 12; r++) begin
      read_row(4'(r), v);
      tests_run++;
      if (v !== exp_init(r)) begin
        tests_failed++;
        $display("[TB] FAIL init_row%0d: got %h, expected %h", r, v, exp_init(r));
      end
    end
  endtask

  task automatic test_set_clear();
    logic [19:0] v;
    @(negedge clk);
    drive_cmd(2'b00, 4'd5, 5'd3, 20'h0);
    read_row(4'd5, v);
    tests_run++;
    if (v !== 20'h80001) begin
      tests_failed++;
      $display("[TB] FAIL set_prewrite: got %h, expected 80001", v);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    read_row(4'd5, v);
    tests_run++;
    if (v !== 20'h90001 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL set_cell: row=%h err=%b, expected 90001 0", v, err);
    end
    drive_cmd(2'b01, 4'd5, 5'd3, 20'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    read_row(4'd5, v);
    tests_run++;
    if (v !== 20'h80001 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_cell: row=%h err=%b, expected 80001 0", v, err);
    end
  endtask

  task automatic test_reject();
    logic [1:0]  ops  [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
    logic [3:0]  rows [4] = '{4'd0, 4'd4, 4'd4, 4'd9};
    logic [4:0]  cols [4] = '{5'd4, 5'd19, 5'd25, 5'd0};
    logic [19:0] v;
    for (int k = 0; k < 4; k++) begin
      drive_cmd(ops[k], rows[k], cols[k], 20'h00000);
      @(negedge clk);
      cmd_valid = 1'b0;
      tests_run++;
      if (err !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL reject_err case %0d: err=%b, expected 1", k, err);
      end
      @(negedge clk);
      tests_run++;
      if (err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reject_pulse case %0d: err=%b, expected 0", k, err);
      end
    end
    read_row(4'd0, v);
    tests_run++;
    if (v !== 20'hFFFFF) begin
      tests_failed++;
      $display("[TB] FAIL reject_row0: got %h, expected FFFFF", v);
    end
    read_row(4'd4, v);
    tests_run++;
    if (v !== 20'h80001) begin
      tests_failed++;
      $display("[TB] FAIL reject_row4: got %h, expected 80001", v);
    end
    read_row(4'd9, v);
    tests_run++;
    if (v !== 20'hFFFFF) begin
      tests_failed++;
      $display("[TB] FAIL reject_row9: got %h, expected FFFFF", v);
    end
  endtask

  task automatic test_write_row();
    logic [19:0] v;
    drive_cmd(2'b10, 4'd4, 5'd0, 20'h00000);
    @(negedge clk);
    cmd_valid = 1'b0;
    read_row(4'd4, v);
    tests_run++;
    if (v !== 20'h80001 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_row_zero: row=%h err=%b, expected 80001 0", v, err);
    end
    drive_cmd(2'b10, 4'd4, 5'd0, 20'h7FFFE);
    @(negedge clk);
    cmd_valid = 1'b0;
    read_row(4'd4, v);
    tests_run++;
    if (v !== 20'hFFFFF) begin
      tests_failed++;
      $display("[TB] FAIL write_row_full: got %h, expected FFFFF", v);
    end
    drive_cmd(2'b10, 4'd4, 5'd0, 20'h12340);
    @(negedge clk);
    cmd_valid = 1'b0;
    read_row(4'd4, v);
    tests_run++;
    if (v !== 20'h92341) begin
      tests_failed++;
      $display("[TB] FAIL write_row_mixed: got %h, expected 92341", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] v;
    drive_cmd(2'b00, 4'd3, 5'd1, 20'h0);
    @(negedge clk);
    drive_cmd(2'b00, 4'd3, 5'd2, 20'h0);
    read_row(4'd3, v);
    tests_run++;
    if (v !== 20'hC0001) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got %h, expected C0001", v);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    read_row(4'd3, v);
    tests_run++;
    if (v !== 20'hE0001) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got %h, expected E0001", v);
    end
  endtask

  task automatic test_clear_map();
    logic [19:0] v;
    int low_cycles;
    drive_cmd(2'b11, 4'd0, 5'd0, 20'h0);
    @(negedge clk);
    drive_cmd(2'b00, 4'd2, 5'd10, 20'h0);
    low_cycles = 0;
    tests_run++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_start: busy=%b ready=%b, expected 1 0", busy, cmd_ready);
    end
    if (cmd_ready === 1'b0) low_cycles++;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b0) low_cycles++;
    end
    tests_run++;
    if (low_cycles != 10) begin
      tests_failed++;
      $display("[TB] FAIL clear_ready_low: %0d cycles, expected 10", low_cycles);
    end
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_done: ready=%b busy=%b, expected 1 0", cmd_ready, busy);
    end
    read_row(4'd3, v);
    tests_run++;
    if (v !== 20'h80001) begin
      tests_failed++;
      $display("[TB] FAIL clear_row3: got %h, expected 80001", v);
    end
    read_row(4'd4, v);
    tests_run++;
    if (v !== 20'h80001) begin
      tests_failed++;
      $display("[TB] FAIL clear_row4: got %h, expected 80001", v);
    end
    read_row(4'd2, v);
    tests_run++;
    if (v !== 20'h80001) begin
      tests_failed++;
      $display("[TB] FAIL clear_pending_held: got %h, expected 80001", v);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    read_row(4'd2, v);
    tests_run++;
    if (v !== 20'h80201 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_pending_accept: row=%h err=%b, expected 80201 0", v, err);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [19:0] v;
    drive_cmd(2'b11, 4'd0, 5'd0, 20'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    read_row(4'd2, v);
    tests_run++;
    if (v !== 20'h00000 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midfill_reset: row2=%h busy=%b ready=%b, expected 00000 1 0", v, busy, cmd_ready);
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== (i < 10) || cmd_ready !== (i >= 10)) begin
        tests_failed++;
        $display("[TB] FAIL midfill_busy cycle %0d: busy=%b ready=%b, expected %b %b", i, busy, cmd_ready, (i < 10), (i >= 10));
      end
    end
    for (int r = 0; r < 10; r++) begin
      read_row(4'(r), v);
      tests_run++;
      if (v !== exp_init(r)) begin
        tests_failed++;
        $display("[TB] FAIL midfill_row%0d: got %h, expected %h", r, v, exp_init(r));
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_reject();
    test_write_row();
    test_back_to_back();
    test_clear_map();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
